// File: rtl/sr_serial_pkg.sv
// sr_serial_pkg: state encoding and ALU shift opcodes shared by the serial shifter
package sr_serial_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
endpackage

// File: rtl/sr_serial_srx_1.sv
// srx_1: single-position right shift with caller-supplied fill bit
module srx_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             fill,
  output logic [WIDTH-1:0] y
);
  assign y = {fill, a[WIDTH-1:1]};
endmodule

// File: rtl/sr_serial.sv
// sr_serial: multicycle logical/arithmetic right shifter, one bit per cycle
module sr_serial
  import sr_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic             ctrl_arith,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [SHW-1:0]   ctrl_shamt,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             busy
);
  state_t           state;
  logic [WIDTH-1:0] sreg, shifted;
  logic [SHW-1:0]   count;
  logic             fill;
  srx_1 #(.WIDTH(WIDTH)) u_srx (.a(sreg), .fill(fill), .y(shifted));
  assign data_result = sreg;
  // DONE accepts a new start just like IDLE, giving back-to-back operation
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state          <= IDLE;
      sreg           <= '0;
      count          <= '0;
      fill           <= 1'b0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_start) begin
            sreg  <= data_operandA;
            count <= ctrl_shamt;
            fill  <= ctrl_arith & data_operandA[WIDTH-1];
            busy  <= 1'b1;
            state <= SHIFT;
          end else state <= IDLE;
        end
        SHIFT:
          if (count != '0) begin
            sreg  <= shifted;
            count <= count - SHW'(1);
          end else begin
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            state          <= DONE;
          end
        default: begin
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_sr_serial.sv
// tb_sr_serial: scoreboard bench for sr_serial with a >>/>>> reference model
module tb_sr_serial;
  logic        clock = 0, reset = 1, ctrl_start = 0, ctrl_arith = 0;
  logic [31:0] data_operandA = 0;
  logic [4:0]  ctrl_shamt = 0;
  logic [31:0] data_result;
  logic        data_resultRDY, busy;
  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;

  sr_serial dut (
    .clock(clock), .reset(reset), .ctrl_start(ctrl_start), .ctrl_arith(ctrl_arith),
    .data_operandA(data_operandA), .ctrl_shamt(ctrl_shamt),
    .data_result(data_result), .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input int sh, input bit ar);
    return ar ? 32'($signed(a) >>> sh) : a >> sh;
  endfunction

  always @(negedge clock)
    if (!reset && data_resultRDY) begin
      chk("busy_at_rdy", 32'(busy), 0);
      if (q.size() == 0) chk("unexpected_rdy", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", data_result, e.res);
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end

  task automatic issue(input logic [31:0] a, input int sh, input bit ar, input logic [31:0] exp);
    int n = 0;
    @(negedge clock);
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) chk("busy_timeout", 1, 0);
    ctrl_start = 1;
    data_operandA = a;
    ctrl_shamt = 5'(sh);
    ctrl_arith = ar;
    q.push_back('{res: exp, acc: cyc + 1, lat: sh + 1});
    @(posedge clock);
    #1;
    ctrl_start = 0;
    data_operandA = $urandom;
    ctrl_shamt = 5'($urandom_range(0, 31));
    ctrl_arith = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse(input logic [31:0] a, input int sh, input bit ar);
    @(negedge clock);
    ctrl_start = 1;
    data_operandA = a;
    ctrl_shamt = 5'(sh);
    ctrl_arith = ar;
    @(posedge clock);
    #1;
    ctrl_start = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held, a;
    int sh;
    bit ar;
    repeat (2) @(negedge clock);
    chk("reset_result", data_result, 0);
    chk("reset_rdy", 32'(data_resultRDY), 0);
    chk("reset_busy", 32'(busy), 0);
    reset = 0;
    // SRL with busy profile: five SHIFT cycles, then RDY with busy low
    issue(32'h8000_00F0, 4, 0, 32'h0800_000F);
    repeat (5) begin
      @(negedge clock);
      chk("srl_busy_high", 32'(busy), 1);
    end
    @(negedge clock);
    chk("srl_busy_low", 32'(busy), 0);
    drain();
    issue(32'h8000_00F0, 4, 1, 32'hF800_000F);
    issue(32'h7FFF_FFFF, 31, 1, 32'h0000_0000);
    issue(32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
    issue(32'h8000_0000, 31, 1, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 31, 0, 32'h0000_0001);
    drain();
    // start pulsed mid-shift must be dropped
    issue(32'h1234_5678, 10, 0, 32'h0004_8D15);
    repeat (2) @(negedge clock);
    pulse(32'hFFFF_FFFF, 1, 1);
    drain();
    held = data_result;
    chk("held_value", held, 32'h0004_8D15);
    repeat (10) begin
      @(negedge clock);
      chk("idle_stable", data_result, held);
    end
    // reset mid-shift aborts with no RDY
    issue(32'hCAFE_F00D, 20, 1, 32'h0);
    repeat (5) @(negedge clock);
    #1 reset = 1;
    q.delete();
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdy", 32'(data_resultRDY), 0);
    chk("abort_result", data_result, 0);
    @(negedge clock);
    reset = 0;
    repeat (30) @(negedge clock);
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      sh = $urandom_range(0, 31);
      ar = 1'($urandom_range(0, 1));
      issue(a, sh, ar, model(a, sh, ar));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clock);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
